// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction loader and the 3-bit-opcode control decoder.
// Holds the word layout, the opcode encoding and the loader state type.
package isa_pkg;

   localparam int unsigned OPW  = 3;
   localparam int unsigned ARGW = 6;
   localparam int unsigned IW   = OPW + ARGW;

   typedef enum logic [OPW-1:0] {
      OP_LDR   = 3'b000,
      OP_STR   = 3'b001,
      OP_MOV   = 3'b010,
      OP_XOR   = 3'b011,
      OP_AND   = 3'b100,
      OP_SHIFT = 3'b101,
      OP_CMP   = 3'b110,
      OP_BR    = 3'b111
   } op_e;

   // Opcode in the top bits, operand field below; BR's arg is a LUT index kept verbatim.
   typedef struct packed {
      op_e             op;
      logic [ARGW-1:0] arg;
   } instr_t;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_LOAD,
      LD_DONE,
      LD_ERR
   } ld_state_e;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packing of an opcode/operand record into a machine word.
// Keeps the word encoding in one place for the loader.
module instr_word_pack
   import isa_pkg::*;
(
   input  logic [OPW-1:0]  op,
   input  logic [ARGW-1:0] arg,
   output instr_t          word
);

   always_comb begin
      word     = '0;
      word.op  = op_e'(op);
      word.arg = arg;
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams instruction records into instruction memory, one word per accepted record,
// then pulses core_start. Optional running XOR checksum output under LOADER_CHECKSUM_EN.
module instr_mem_loader
   import isa_pkg::*;
#(
   parameter int unsigned AW = 10
)(
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_op,
   input  logic [ARGW-1:0] in_arg,
   input  logic            in_last,
   output logic            im_we,
   output logic [AW-1:0]   im_addr,
   output logic [IW-1:0]   im_wdata,
   output logic [AW:0]     prog_len,
   output logic            core_start,
   output logic            busy,
   output logic            overflow
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [IW-1:0]   prog_csum
`endif
);

   ld_state_e   state;
   logic [AW:0] ptr;
   instr_t      word;
   logic        accept;

   instr_word_pack u_pack (
      .op   (in_op),
      .arg  (in_arg),
      .word (word)
   );

   // ptr[AW] set means the memory is full (ptr == 2**AW).
   assign in_ready = (state == LD_LOAD) && !ptr[AW];
   assign accept   = in_valid && in_ready;
   assign busy     = (state != LD_IDLE);
   assign prog_len = ptr;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= LD_IDLE;
         ptr        <= '0;
         overflow   <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         core_start <= 1'b0;
      end else begin
         im_we      <= 1'b0;
         core_start <= 1'b0;
         unique case (state)
            LD_IDLE, LD_ERR: begin
               if (start) begin
                  state    <= LD_LOAD;
                  ptr      <= '0;
                  overflow <= 1'b0;
               end
            end
            LD_LOAD: begin
               if (accept) begin
                  im_we    <= 1'b1;
                  im_addr  <= ptr[AW-1:0];
                  im_wdata <= word;
                  ptr      <= ptr + (AW+1)'(1);
                  if (in_last) state <= LD_DONE;
               end else if (in_valid && ptr[AW]) begin
                  overflow <= 1'b1;
                  state    <= LD_ERR;
               end
            end
            LD_DONE: begin
               core_start <= 1'b1;
               state      <= LD_IDLE;
            end
            default: state <= LD_IDLE;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [IW-1:0] csum;

   // Folds in each word during its write cycle, so the sum is complete when core_start rises.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         csum <= '0;
      end else if (start && (state == LD_IDLE || state == LD_ERR)) begin
         csum <= '0;
      end else if (im_we) begin
         csum <= csum ^ im_wdata;
      end
   end

   assign prog_csum = csum;
`endif

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer-side counterpart to the 3-bit-opcode control decoder.
- Accepts assembled instruction records (opcode + operand field) over a valid/ready stream.
- Encodes each record into a 9-bit machine word and writes it sequentially into instruction memory.
- Sits between the host/testbench program source and the instruction ROM/RAM; releases the core to run once the program is loaded.

Parameters:
- OPW, 3, opcode width; matches the decoder's mcodebits.
- ARGW, 6, operand field width; machine word = OPW+ARGW = 9 bits.
- AW, 10, instruction memory address width; depth = 2**AW.

Ports:
- Clk  in  1  clock
- Reset_n  in  1  synchronous, active-low reset
- start  in  1  pulse: begin a load session at address 0
- in_valid  in  1  record valid
- in_ready  out  1  loader can accept a record this cycle
- in_op  in  OPW  opcode (000 LDR, 001 STR, 010 MOV/ADD, 011 XOR, 100 AND, 101 SHIFT, 110 CMP, 111 BR)
- in_arg  in  ARGW  operand field
- in_last  in  1  marks the final record of the program
- im_we  out  1  instruction memory write enable
- im_addr  out  AW  write address
- im_wdata  out  OPW+ARGW  machine word {op, arg}
- prog_len  out  AW+1  number of words written in the current/last session
- core_start  out  1  one-cycle pulse when load completes cleanly
- busy  out  1  session in progress
- overflow  out  1  sticky: record offered while memory full

Behaviour:
- Reset: Clk edge with Reset_n=0.
  - State goes to IDLE.
  - im_we, im_addr, im_wdata, prog_len, core_start, overflow, in_ready all 0.
  - Reset mid-session aborts immediately; no further writes.
- States:
  - IDLE:
    - in_ready=0.
    - start -> LOAD; write pointer cleared to 0; prog_len cleared to 0; overflow cleared.
  - LOAD:
    - in_ready = (ptr < 2**AW).
    - Handshake on in_valid && in_ready.
    - in_last accepted -> DONE.
    - in_valid while ptr == 2**AW: overflow set sticky -> ERR.
  - DONE: one cycle; core_start=1; -> IDLE.
  - ERR:
    - Holds, in_ready=0, no core_start.
    - Exits only on start (-> LOAD, fresh session) or reset.
- Write pipeline, fixed 1-cycle latency:
  - A record accepted at edge N gives im_we=1 during cycle N+1, with im_addr=ptr and im_wdata={in_op,in_arg} registered.
  - ptr and prog_len increment at edge N.
  - Back-to-back records write every cycle.
- core_start asserts in the cycle after the last write's im_we cycle, never overlapping a write.
- start while busy (LOAD/DONE) is ignored; start in ERR restarts.
- Exactly 2**AW records with the last flagged on record 2**AW: clean DONE, prog_len = 2**AW (hence AW+1 bits), no overflow.
- No opcode filtering: all 8 opcodes are encoded verbatim. The BR arg field is a branch-target LUT index and passes unmodified.
- busy = state != IDLE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN
- With it defined:
  - Adds output prog_csum (OPW+ARGW bits), the running XOR of all written words.
  - Cleared on start and reset; updated with each im_we word.
  - Valid and stable when core_start pulses.
- Without it: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package isa_pkg:
  - OPW, ARGW, instruction word typedef instr_t (struct: op, arg).
  - opcode enum op_e (LDR..BR), matching the decoder's encoding.
  - Loader state enum ld_state_e.
- isa_pkg is also importable by the decoder.
- One natural sub-module: instr_word_pack, combinational op/arg -> instr_t packing; keeps the encoding in one place.

Test Plan:
- Basic load: start, then 3 records (010/000101, 111/000010, 001/111111 last) back-to-back.
  - Writes addr 0,1,2 with data 0x085, 0x1C2, 0x07F on consecutive cycles.
  - core_start 1 cycle after the final write; prog_len=3.
- Stalled source: in_valid toggling 1,0,0,1(last).
  - Exactly 2 writes at addr 0,1; no write in bubble cycles; prog_len=2.
- Full boundary (AW=2): 4 records with last on the 4th -> clean DONE, prog_len=4.
  - Repeat with no last: 5th record -> in_ready=0, overflow=1, state ERR, no core_start.
  - A subsequent start clears overflow.
- Reset mid-load: Reset_n=0 after 2 of 5 records.
  - Next cycle im_we=0, busy=0, prog_len=0; remaining records never written.
- start ignored while busy: start pulse mid-session -> ptr is not reset, addresses keep incrementing.
- LOADER_CHECKSUM_EN: words 0x085, 0x1C2, 0x07F -> prog_csum = 0x138 at core_start.
